movegen_sequencer: RTL and testbench

Sequencer for the 64-square move-generator array. Accepts a board as a stream of 64 piece nibbles, shifts it into the square chain, then walks every square holding a side-to-move piece, asserts that square's emit strobe and captures the resulting 64-bit target vector. Each (from, to) pair is presented on a valid/ready move stream. Sits between the board-source/search logic and the square array.

---
 rtl/movegen_pkg.sv | 30 +++
 rtl/movegen_sequencer_lsb_pick.sv | 22 ++
 rtl/movegen_sequencer.sv | 155 +++++++++++++++
 tb/tb_movegen_sequencer.sv | 281 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/movegen_pkg.sv
// Shared types and constants for the move-generator sequencer.
// Piece nibbles: bits [2:0] give the piece type, bit 3 gives the colour (1 = white).
package movegen_pkg;

  localparam int unsigned NSQ  = 64;
  localparam int unsigned SQ_W = 6;

  localparam logic [2:0] P_KING   = 3'd1;
  localparam logic [2:0] P_QUEEN  = 3'd2;
  localparam logic [2:0] P_ROOK   = 3'd3;
  localparam logic [2:0] P_BISHOP = 3'd4;
  localparam logic [2:0] P_KNIGHT = 3'd5;
  localparam logic [2:0] P_PAWN   = 3'd6;
  localparam int unsigned WHITE_BIT = 3;

  typedef enum logic [2:0] {
    StIdle,
    StLoad,
    StPick,
    StEmit,
    StDrain,
    StDone
  } state_t;

  // True when the nibble holds a piece that belongs to the side to move.
  function automatic logic is_own(input logic [3:0] nib, input logic wtp);
    return (nib[2:0] != 3'd0) && (nib[WHITE_BIT] == wtp);
  endfunction

endpackage

// File: rtl/movegen_sequencer_lsb_pick.sv
// Lowest-set-bit priority encoder over a 64-bit square vector.
// It also returns the input vector with that lowest set bit cleared.
module lsb_pick
  import movegen_pkg::*;
(
  input  logic [NSQ-1:0]  vec,
  output logic [SQ_W-1:0] idx,
  output logic            any,
  output logic [NSQ-1:0]  mask_cleared
);

  always_comb begin
    idx = '0;
    // Scan downward so that the lowest set bit is the last one written.
    for (int i = NSQ - 1; i >= 0; i--) begin
      if (vec[i]) idx = SQ_W'(i);
    end
    any          = |vec;
    mask_cleared = vec & (vec - NSQ'(1));
  end

endmodule

// File: rtl/movegen_sequencer.sv
// Move-generation sequencer: shifts a board into the square array, strobes each own piece
// in ascending square order and streams out every (from, to) pair reported by the array.
module movegen_sequencer #(
  parameter int unsigned NSQ = 64
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        i_start,
  input  logic                        i_wtp,
  input  logic [3:0]                  i_castle_rights,
  input  logic                        i_board_valid,
  input  logic [3:0]                  i_board_data,
  output logic                        o_board_ready,
  output logic                        o_pos_valid,
  output logic [3:0]                  o_pos_data,
  output logic                        o_wtp,
  output logic [3:0]                  o_castle_rights,
  output logic [NSQ-1:0]              o_emit,
  input  logic [NSQ-1:0]              i_target,
  output logic                        o_move_valid,
  input  logic                        i_move_ready,
  output logic [movegen_pkg::SQ_W-1:0] o_move_from,
  output logic [movegen_pkg::SQ_W-1:0] o_move_to,
  output logic                        o_done,
  output logic [7:0]                  o_move_count,
  output logic                        o_busy
);

  import movegen_pkg::*;

  state_t            state_q, state_d;
  logic              wtp_q, wtp_d;
  logic [3:0]        castle_q, castle_d;
  logic [NSQ-1:0]    own_q, own_d;
  logic [NSQ-1:0]    tgt_q, tgt_d;
  logic [SQ_W-1:0]   src_q, src_d;
  logic [SQ_W-1:0]   ld_cnt_q, ld_cnt_d;
  logic [7:0]        cnt_q, cnt_d;

  logic [SQ_W-1:0]   own_idx, tgt_idx;
  logic              own_any, tgt_any;
  logic [NSQ-1:0]    own_clr, tgt_clr;

  lsb_pick u_own_pick (
    .vec          (own_q),
    .idx          (own_idx),
    .any          (own_any),
    .mask_cleared (own_clr)
  );

  lsb_pick u_tgt_pick (
    .vec          (tgt_q),
    .idx          (tgt_idx),
    .any          (tgt_any),
    .mask_cleared (tgt_clr)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= StIdle;
      wtp_q    <= 1'b0;
      castle_q <= '0;
      own_q    <= '0;
      tgt_q    <= '0;
      src_q    <= '0;
      ld_cnt_q <= '0;
      cnt_q    <= '0;
    end else begin
      state_q  <= state_d;
      wtp_q    <= wtp_d;
      castle_q <= castle_d;
      own_q    <= own_d;
      tgt_q    <= tgt_d;
      src_q    <= src_d;
      ld_cnt_q <= ld_cnt_d;
      cnt_q    <= cnt_d;
    end
  end

  always_comb begin
    state_d       = state_q;
    wtp_d         = wtp_q;
    castle_d      = castle_q;
    own_d         = own_q;
    tgt_d         = tgt_q;
    src_d         = src_q;
    ld_cnt_d      = ld_cnt_q;
    cnt_d         = cnt_q;
    o_board_ready = 1'b0;
    o_pos_valid   = 1'b0;
    o_pos_data    = 4'h0;
    o_emit        = '0;
    o_move_valid  = 1'b0;
    o_done        = 1'b0;

    unique case (state_q)
      StIdle: begin
        if (i_start) begin
          wtp_d    = i_wtp;
          castle_d = i_castle_rights;
          own_d    = '0;
          ld_cnt_d = '0;
          cnt_d    = '0;
          state_d  = StLoad;
        end
      end
      StLoad: begin
        o_board_ready = 1'b1;
        if (i_board_valid) begin
          o_pos_valid = 1'b1;
          o_pos_data  = i_board_data;
          // Own-mask bit n tracks array square n as the chain shifts upward.
          own_d       = {own_q[NSQ-2:0], is_own(i_board_data, wtp_q)};
          ld_cnt_d    = ld_cnt_q + 1'b1;
          if (ld_cnt_q == SQ_W'(NSQ - 1)) state_d = StPick;
        end
      end
      StPick: begin
        if (!own_any) begin
          state_d = StDone;
        end else begin
          src_d   = own_idx;
          own_d   = own_clr;
          state_d = StEmit;
        end
      end
      StEmit: begin
        o_emit  = NSQ'(1) << src_q;
        tgt_d   = i_target;
        state_d = (i_target == '0) ? StPick : StDrain;
      end
      StDrain: begin
        o_move_valid = tgt_any;
        if (i_move_ready) begin
          tgt_d = tgt_clr;
          cnt_d = (cnt_q == 8'hFF) ? cnt_q : cnt_q + 8'd1;
          if (tgt_clr == '0) state_d = StPick;
        end
      end
      StDone: begin
        o_done  = 1'b1;
        state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  assign o_busy          = (state_q != StIdle);
  assign o_wtp           = wtp_q;
  assign o_castle_rights = castle_q;
  assign o_move_from     = src_q;
  assign o_move_to       = tgt_idx;
  assign o_move_count    = cnt_q;

endmodule

// File: tb/tb_movegen_sequencer.sv
// Self-checking bench for movegen_sequencer with a stub square array and a move-list model.
module tb_movegen_sequencer;

  logic        clk = 1'b0;
  logic        rst;
  logic        i_start, i_wtp, i_board_valid, i_move_ready;
  logic [3:0]  i_castle_rights, i_board_data;
  logic        o_board_ready, o_pos_valid, o_wtp, o_move_valid, o_done, o_busy;
  logic [3:0]  o_pos_data, o_castle_rights;
  logic [63:0] o_emit, i_target;
  logic [5:0]  o_move_from, o_move_to;
  logic [7:0]  o_move_count;

  movegen_sequencer #(.NSQ(64)) dut (
    .clk             (clk),
    .rst             (rst),
    .i_start         (i_start),
    .i_wtp           (i_wtp),
    .i_castle_rights (i_castle_rights),
    .i_board_valid   (i_board_valid),
    .i_board_data    (i_board_data),
    .o_board_ready   (o_board_ready),
    .o_pos_valid     (o_pos_valid),
    .o_pos_data      (o_pos_data),
    .o_wtp           (o_wtp),
    .o_castle_rights (o_castle_rights),
    .o_emit          (o_emit),
    .i_target        (i_target),
    .o_move_valid    (o_move_valid),
    .i_move_ready    (i_move_ready),
    .o_move_from     (o_move_from),
    .o_move_to       (o_move_to),
    .o_done          (o_done),
    .o_move_count    (o_move_count),
    .o_busy          (o_busy)
  );

  always #5 clk = ~clk;

  // Stub array: board chain shifted by o_pos_valid, targets looked up per strobed square.
  logic [3:0]  board [64];
  logic [3:0]  tb_chain [64];
  logic [63:0] tgt_map [64];

  always @(posedge clk) begin
    if (o_pos_valid) begin
      for (int i = 63; i > 0; i--) tb_chain[i] <= tb_chain[i-1];
      tb_chain[0] <= o_pos_data;
    end
  end

  always_comb begin
    i_target = '0;
    for (int s = 0; s < 64; s++) if (o_emit[s]) i_target = i_target | tgt_map[s];
  end

  int errs = 0;
  int checks = 0;
  logic [11:0] exp_q[$];
  int own_sq[$];
  int exp_total, exp_cycles;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errs++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  function automatic bit own(input logic [3:0] nib, input logic w);
    return (nib[2:0] != 3'd0) && (nib[3] == w);
  endfunction

  // Expected pass: own squares ascending, each target ascending; cycles with ready held high.
  task automatic build_model(input logic w);
    exp_q.delete();
    own_sq.delete();
    exp_cycles = 1;
    for (int s = 0; s < 64; s++) begin
      if (own(board[s], w)) begin
        own_sq.push_back(s);
        exp_cycles += 2;
        for (int t = 0; t < 64; t++) begin
          if (tgt_map[s][t]) begin
            exp_q.push_back({6'(s), 6'(t)});
            exp_cycles++;
          end
        end
      end
    end
    exp_total = exp_q.size();
  endtask

  task automatic clear_board();
    for (int s = 0; s < 64; s++) begin
      board[s]   = 4'h0;
      tgt_map[s] = '0;
    end
  endtask

  task automatic random_board(input bit dense);
    for (int s = 0; s < 64; s++) begin
      int r;
      r = $urandom_range(0, 11);
      board[s] = ($urandom_range(0, 1) == 0) ? 4'h0 : 4'((r < 6) ? r + 1 : r + 3);
      if (dense) tgt_map[s] = '1;
      else if ($urandom_range(0, 3) == 0) tgt_map[s] = '0;
      else tgt_map[s] = {$urandom, $urandom} & {$urandom, $urandom} & {$urandom, $urandom};
    end
  endtask

  // rmode: 0 ready high, 1 random ready, 2 ready low for 10 cycles at first move.
  task automatic run_pass(input logic w, input bit gappy, input int rmode, input int rst_after,
                          input bit start_noise);
    logic [3:0] castle;
    int idx, cycles, n, emits, accepts, hold_left, mism;
    bit hold_started, prev_hold, done_seen;
    logic [5:0] prev_from, prev_to;
    logic [11:0] e;

    build_model(w);
    castle = 4'($urandom);
    i_wtp = w;
    i_castle_rights = castle;
    i_start = 1'b1;
    cyc();
    i_start = 1'b0;
    i_castle_rights = ~castle;
    chk("start_busy", o_busy, 1);
    chk("start_ready", o_board_ready, 1);
    chk("latched_wtp", o_wtp, w);
    chk("latched_castle", o_castle_rights, castle);
    chk("count_cleared", o_move_count, 0);

    idx = 0;
    cycles = 0;
    while (idx < 64 && cycles < 400) begin
      i_board_valid = gappy ? cycles[0] : 1'b1;
      i_board_data  = board[63 - idx];
      #1;
      chk("pos_valid", o_pos_valid, i_board_valid);
      if (i_board_valid) chk("pos_data", o_pos_data, i_board_data);
      idx += int'(i_board_valid);
      cycles++;
      cyc();
    end
    i_board_valid = 1'b0;
    chk("load_cycles", cycles, gappy ? 128 : 64);
    mism = 0;
    for (int s = 0; s < 64; s++) if (tb_chain[s] !== board[s]) mism++;
    chk("chain_contents", mism, 0);

    n = 0; emits = 0; accepts = 0; hold_left = 10;
    hold_started = 0; prev_hold = 0; done_seen = 0;
    prev_from = '0; prev_to = '0;
    if (start_noise) i_start = 1'b1;
    while (n < 20000) begin
      if (prev_hold) begin
        chk("hold_valid", o_move_valid, 1);
        chk("hold_from", o_move_from, prev_from);
        chk("hold_to", o_move_to, prev_to);
      end
      if (rmode == 0) i_move_ready = 1'b1;
      else if (rmode == 1) i_move_ready = 1'($urandom_range(0, 1));
      else begin
        if (!hold_started && o_move_valid) hold_started = 1;
        if (hold_started && hold_left > 0) begin
          i_move_ready = 1'b0;
          hold_left--;
        end else i_move_ready = 1'b1;
      end
      if (o_pos_valid || o_board_ready) chk("no_load_after", {o_pos_valid, o_board_ready}, 0);
      if (o_emit != '0) begin
        emits++;
        if (emits <= own_sq.size()) chk("emit", o_emit, 64'd1 << own_sq[emits-1]);
        else chk("emit_extra", o_emit, 0);
      end
      if (o_move_valid && i_move_ready) begin
        accepts++;
        if (exp_q.size() == 0) chk("move_extra", {o_move_from, o_move_to}, 12'hFFF);
        else begin
          e = exp_q.pop_front();
          chk("move", {o_move_from, o_move_to}, e);
        end
        if (rst_after > 0 && accepts == rst_after) begin
          rst = 1'b1;
          #1;
          chk("rst_outputs", {o_board_ready, o_pos_valid, o_emit, o_move_valid, o_done, o_busy,
                              o_pos_data, o_move_from, o_move_to, o_move_count, o_wtp,
                              o_castle_rights}, 0);
          cyc();
          rst = 1'b0;
          i_move_ready = 1'b1;
          i_start = 1'b0;
          for (int k = 0; k < 5; k++) begin
            cyc();
            chk("post_rst_quiet", {o_move_valid, o_emit, o_busy}, 0);
          end
          return;
        end
      end
      prev_hold = o_move_valid && !i_move_ready;
      prev_from = o_move_from;
      prev_to   = o_move_to;
      if (o_done) begin
        done_seen = 1;
        break;
      end
      cyc();
      n++;
    end
    chk("done_seen", done_seen, 1);
    chk("move_count", o_move_count, (exp_total > 255) ? 255 : exp_total);
    chk("moves_left", exp_q.size(), 0);
    chk("emit_count", emits, own_sq.size());
    if (rmode == 0) chk("pass_cycles", n, exp_cycles);
    cyc();
    i_start = 1'b0;
    i_move_ready = 1'b0;
    chk("idle_after_done", {o_busy, o_done}, 0);
    chk("count_held", o_move_count, (exp_total > 255) ? 255 : exp_total);
    cyc();
    chk("still_idle", o_busy, 0);
  endtask

  initial begin
    rst = 1'b1;
    i_start = 0; i_wtp = 0; i_castle_rights = 0; i_board_valid = 0; i_board_data = 0;
    i_move_ready = 0;
    clear_board();
    for (int s = 0; s < 64; s++) tb_chain[s] = 4'h0;
    #1;
    chk("reset_outputs", {o_board_ready, o_pos_valid, o_emit, o_move_valid, o_done, o_busy,
                          o_pos_data, o_move_from, o_move_to, o_move_count, o_wtp,
                          o_castle_rights}, 0);
    cyc();
    cyc();
    rst = 1'b0;
    cyc();
    chk("idle_no_start", o_busy, 0);

    // Empty board, white to move.
    run_pass(1'b1, 0, 0, 0, 0);

    // Lone white king on e1 (square 4) with five reported targets.
    clear_board();
    board[4] = 4'h9;
    tgt_map[4] = 64'h3828;
    run_pass(1'b1, 0, 0, 0, 0);
    chk("king_count", o_move_count, 5);
    run_pass(1'b1, 0, 2, 0, 0);
    run_pass(1'b0, 0, 0, 0, 0);
    chk("king_black_count", o_move_count, 0);

    // Reset mid-drain, then a full rerun.
    run_pass(1'b1, 0, 1, 3, 0);
    run_pass(1'b1, 1, 0, 0, 0);

    // Random boards: gappy loads, random ready, stray i_start during the pass.
    for (int p = 0; p < 3; p++) begin
      random_board(0);
      run_pass(1'($urandom_range(0, 1)), 1'(p), 1, 0, 1);
    end
    random_board(0);
    run_pass(1'b0, 0, 0, 0, 0);

    // Every square reports every target: count saturates.
    random_board(1);
    run_pass(1'b1, 0, 0, 0, 0);

    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end

endmodule
